// File: rtl/robo_tracker.sv
// Passive pose/command tracker for the robot controller outputs.
// Optional stuck-robot detection is compiled in when TRACKER_STUCK_EN is defined.
module robo_tracker #(
  parameter int GRID_W    = 16,
  parameter int GRID_H    = 16,
  parameter int START_ROW = 0,
  parameter int START_COL = 0,
  parameter int START_DIR = 2,
  parameter int CNT_W     = 16,
  localparam int RW = (GRID_H > 1) ? $clog2(GRID_H) : 1,
  localparam int CW = (GRID_W > 1) ? $clog2(GRID_W) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             avancar,
  input  logic             girar,
  input  logic             remover,
  output logic [RW-1:0]    row,
  output logic [CW-1:0]    col,
  output logic [1:0]       dir,
  output logic [CNT_W-1:0] step_count,
  output logic [CNT_W-1:0] turn_count,
  output logic [CNT_W-1:0] remove_count,
  output logic [CNT_W-1:0] lap_count,
  output logic             lap_done,
  output logic             illegal_cmd,
  output logic             out_of_bounds
`ifdef TRACKER_STUCK_EN
  ,
  output logic             stuck
`endif
);

  typedef enum logic [1:0] {DIR_N, DIR_E, DIR_S, DIR_W} dir_e;

  localparam logic [RW-1:0] ROW_START = RW'(START_ROW);
  localparam logic [CW-1:0] COL_START = CW'(START_COL);
  localparam dir_e          DIR_START = dir_e'(2'(START_DIR));
  localparam logic [RW-1:0] ROW_LAST  = RW'(GRID_H - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(GRID_W - 1);

  logic [RW-1:0]    row_q, row_d;
  logic [CW-1:0]    col_q, col_d;
  dir_e             dir_q, dir_d;
  logic [CNT_W-1:0] step_q, step_d, turn_q, turn_d;
  logic [CNT_W-1:0] remove_q, remove_d, lap_q, lap_d;
  logic             lap_done_q, lap_done_d;
  logic             illegal_q, illegal_d;
  logic             oob_q, oob_d;
  logic             moved_q, moved_d;
  logic             pose_changed;
  logic             multi_cmd;
  logic             blocked;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

`ifdef TRACKER_STUCK_EN
  logic [2:0] run_q, run_d;
  logic       stuck_q, stuck_d;
`endif

  assign multi_cmd = (avancar & girar) | (avancar & remover) | (girar & remover);

  always_comb begin
    row_d        = row_q;
    col_d        = col_q;
    dir_d        = dir_q;
    step_d       = step_q;
    turn_d       = turn_q;
    remove_d     = remove_q;
    lap_d        = lap_q;
    lap_done_d   = 1'b0;
    illegal_d    = illegal_q;
    oob_d        = oob_q;
    moved_d      = moved_q;
    pose_changed = 1'b0;
    blocked      = 1'b0;
`ifdef TRACKER_STUCK_EN
    run_d        = run_q;
    stuck_d      = stuck_q;
`endif

    if (multi_cmd) begin
      illegal_d = 1'b1;
    end else if (girar) begin
      dir_d        = dir_e'(dir_q + 2'd1);
      turn_d       = sat_inc(turn_q);
      pose_changed = 1'b1;
`ifdef TRACKER_STUCK_EN
      if (run_q != 3'd7) run_d = run_q + 3'd1;
`endif
    end else if (avancar) begin
      unique case (dir_q)
        DIR_N: if (row_q == '0)      blocked = 1'b1; else row_d = row_q - RW'(1);
        DIR_E: if (col_q == COL_LAST) blocked = 1'b1; else col_d = col_q + CW'(1);
        DIR_S: if (row_q == ROW_LAST) blocked = 1'b1; else row_d = row_q + RW'(1);
        DIR_W: if (col_q == '0)      blocked = 1'b1; else col_d = col_q - CW'(1);
        default: blocked = 1'b1;
      endcase
      if (blocked) begin
        oob_d = 1'b1;
      end else begin
        step_d       = sat_inc(step_q);
        moved_d      = 1'b1;
        pose_changed = 1'b1;
`ifdef TRACKER_STUCK_EN
        run_d        = '0;
`endif
      end
    end else if (remover) begin
      remove_d = sat_inc(remove_q);
    end

    // moved_q (pre-update) gates the lap so the advance that first leaves start cannot count.
    if (pose_changed && moved_q && row_d == ROW_START && col_d == COL_START &&
        dir_d == DIR_START) begin
      lap_done_d = 1'b1;
      lap_d      = sat_inc(lap_q);
      moved_d    = 1'b0;
    end

`ifdef TRACKER_STUCK_EN
    if (run_d >= 3'd4) stuck_d = 1'b1;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      row_q      <= ROW_START;
      col_q      <= COL_START;
      dir_q      <= DIR_START;
      step_q     <= '0;
      turn_q     <= '0;
      remove_q   <= '0;
      lap_q      <= '0;
      lap_done_q <= 1'b0;
      illegal_q  <= 1'b0;
      oob_q      <= 1'b0;
      moved_q    <= 1'b0;
`ifdef TRACKER_STUCK_EN
      run_q      <= '0;
      stuck_q    <= 1'b0;
`endif
    end else begin
      row_q      <= row_d;
      col_q      <= col_d;
      dir_q      <= dir_d;
      step_q     <= step_d;
      turn_q     <= turn_d;
      remove_q   <= remove_d;
      lap_q      <= lap_d;
      lap_done_q <= lap_done_d;
      illegal_q  <= illegal_d;
      oob_q      <= oob_d;
      moved_q    <= moved_d;
`ifdef TRACKER_STUCK_EN
      run_q      <= run_d;
      stuck_q    <= stuck_d;
`endif
    end
  end

  assign row           = row_q;
  assign col           = col_q;
  assign dir           = dir_q;
  assign step_count    = step_q;
  assign turn_count    = turn_q;
  assign remove_count  = remove_q;
  assign lap_count     = lap_q;
  assign lap_done      = lap_done_q;
  assign illegal_cmd   = illegal_q;
  assign out_of_bounds = oob_q;
`ifdef TRACKER_STUCK_EN
  assign stuck         = stuck_q;
`endif

endmodule

// File: tb/tb_robo_tracker.sv
// Scoreboard bench for robo_tracker: two instances (defaults, and a small 5x4 grid
// with START_DIR=1 and 4-bit counters) checked against a behavioural pose model.
module tb_robo_tracker;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic avancar = 1'b0, girar = 1'b0, remover = 1'b0;

  always #5 clock = ~clock;

  // Instance A: default parameters
  logic [3:0]  a_row, a_col;
  logic [1:0]  a_dir;
  logic [15:0] a_step, a_turn, a_rem, a_lap;
  logic        a_lap_done, a_ill, a_oob, a_stuck;

  // Instance B: 5 columns x 4 rows, start heading E, 4-bit counters
  logic [1:0] b_row;
  logic [2:0] b_col;
  logic [1:0] b_dir;
  logic [3:0] b_step, b_turn, b_rem, b_lap;
  logic       b_lap_done, b_ill, b_oob, b_stuck;

  robo_tracker dut_a (
    .clock(clock), .reset(reset), .avancar(avancar), .girar(girar), .remover(remover),
    .row(a_row), .col(a_col), .dir(a_dir),
    .step_count(a_step), .turn_count(a_turn), .remove_count(a_rem), .lap_count(a_lap),
    .lap_done(a_lap_done), .illegal_cmd(a_ill), .out_of_bounds(a_oob)
`ifdef TRACKER_STUCK_EN
    , .stuck(a_stuck)
`endif
  );

  robo_tracker #(
    .GRID_W(5), .GRID_H(4), .START_ROW(0), .START_COL(0), .START_DIR(1), .CNT_W(4)
  ) dut_b (
    .clock(clock), .reset(reset), .avancar(avancar), .girar(girar), .remover(remover),
    .row(b_row), .col(b_col), .dir(b_dir),
    .step_count(b_step), .turn_count(b_turn), .remove_count(b_rem), .lap_count(b_lap),
    .lap_done(b_lap_done), .illegal_cmd(b_ill), .out_of_bounds(b_oob)
`ifdef TRACKER_STUCK_EN
    , .stuck(b_stuck)
`endif
  );

`ifndef TRACKER_STUCK_EN
  assign a_stuck = 1'b0;
  assign b_stuck = 1'b0;
`endif

  typedef struct {
    int row, col, dir;
    int steps, turns, removes, laps;
    int turn_run;
    bit lap, ill, oob, stuck, moved;
  } mstate_t;

  typedef struct {
    mstate_t a;
    mstate_t b;
  } exp_t;

  exp_t    exp_q[$];
  mstate_t ma, mb;
  int      checks = 0;
  int      passed = 0;

  function automatic mstate_t reset_state(int sr, int sc, int sd);
    mstate_t s;
    s = '{default: 0};
    s.row = sr; s.col = sc; s.dir = sd;
    return s;
  endfunction

  // Rules of the tracker expressed on plain integers.
  function automatic mstate_t model_step(mstate_t s, bit rst, bit a, bit g, bit r,
                                         int gw, int gh, int sr, int sc, int sd, int cmax);
    int nr, nc;
    bit changed;
    if (rst) return reset_state(sr, sc, sd);
    s.lap = 0;
    changed = 0;
    if (int'(a) + int'(g) + int'(r) > 1) begin
      s.ill = 1;
    end else if (g) begin
      s.dir = (s.dir + 1) % 4;
      if (s.turns < cmax) s.turns++;
      s.turn_run++;
      changed = 1;
    end else if (a) begin
      nr = s.row + ((s.dir == 2) ? 1 : (s.dir == 0) ? -1 : 0);
      nc = s.col + ((s.dir == 1) ? 1 : (s.dir == 3) ? -1 : 0);
      if (nr < 0 || nr >= gh || nc < 0 || nc >= gw) begin
        s.oob = 1;
      end else begin
        s.row = nr; s.col = nc;
        if (s.steps < cmax) s.steps++;
        s.turn_run = 0;
        changed = 1;
      end
    end else if (r) begin
      if (s.removes < cmax) s.removes++;
    end
    if (changed && s.moved && s.row == sr && s.col == sc && s.dir == sd) begin
      s.lap = 1;
      if (s.laps < cmax) s.laps++;
      s.moved = 0;
    end else if (changed && a) begin
      s.moved = 1;
    end
`ifdef TRACKER_STUCK_EN
    if (s.turn_run >= 4) s.stuck = 1;
`endif
    return s;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act == expv) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
  endtask

  task automatic apply(input bit rst, input bit a, input bit g, input bit r);
    exp_t e;
    @(negedge clock);
    reset = rst; avancar = a; girar = g; remover = r;
    ma = model_step(ma, rst, a, g, r, 16, 16, 0, 0, 2, 65535);
    mb = model_step(mb, rst, a, g, r, 5, 4, 0, 0, 1, 15);
    e.a = ma; e.b = mb;
    exp_q.push_back(e);
  endtask

  task automatic cmd(input int kind, input int n);
    for (int i = 0; i < n; i++) begin
      case (kind)
        0: apply(0, 1, 0, 0);
        1: apply(0, 0, 1, 0);
        2: apply(0, 0, 0, 1);
        default: apply(0, 0, 0, 0);
      endcase
    end
  endtask

  // Monitor: the DUT presents a new state after every edge; compare against the oldest expectation.
  always @(posedge clock) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("a.row", int'(a_row), e.a.row);
      check("a.col", int'(a_col), e.a.col);
      check("a.dir", int'(a_dir), e.a.dir);
      check("a.step_count", int'(a_step), e.a.steps);
      check("a.turn_count", int'(a_turn), e.a.turns);
      check("a.remove_count", int'(a_rem), e.a.removes);
      check("a.lap_count", int'(a_lap), e.a.laps);
      check("a.flags{lap,ill,oob,stuck}", int'({a_lap_done, a_ill, a_oob, a_stuck}),
            int'({e.a.lap, e.a.ill, e.a.oob, e.a.stuck}));
      check("b.row", int'(b_row), e.b.row);
      check("b.col", int'(b_col), e.b.col);
      check("b.dir", int'(b_dir), e.b.dir);
      check("b.step_count", int'(b_step), e.b.steps);
      check("b.turn_count", int'(b_turn), e.b.turns);
      check("b.remove_count", int'(b_rem), e.b.removes);
      check("b.lap_count", int'(b_lap), e.b.laps);
      check("b.flags{lap,ill,oob,stuck}", int'({b_lap_done, b_ill, b_oob, b_stuck}),
            int'({e.b.lap, e.b.ill, e.b.oob, e.b.stuck}));
    end
  end

  initial begin
    int x;
    ma = reset_state(0, 0, 2);
    mb = reset_state(0, 0, 1);

    apply(1, 0, 0, 0);
    apply(1, 0, 0, 0);
    cmd(0, 3);                                   // single moves

    apply(1, 0, 0, 0);                           // square lap (lap on B)
    repeat (4) begin cmd(0, 2); cmd(1, 1); end
    repeat (4) begin cmd(0, 2); cmd(1, 1); end   // second lap

    apply(1, 0, 0, 0);                           // boundary probing
    cmd(1, 3); cmd(0, 1); cmd(1, 1); cmd(0, 1);
    cmd(1, 1); cmd(0, 6);

    apply(1, 0, 0, 0);                           // turning in place, no lap
    cmd(1, 8);

    apply(1, 0, 0, 0);                           // stuck with removes in between
    cmd(1, 3); cmd(0, 1); cmd(1, 1); cmd(2, 1); cmd(1, 2); cmd(3, 1); cmd(1, 1);

    apply(1, 0, 0, 0);                           // illegal combinations stay sticky
    apply(0, 1, 1, 0); cmd(0, 1); cmd(1, 1);
    apply(0, 0, 1, 1); apply(0, 1, 0, 1); apply(0, 1, 1, 1); cmd(2, 1);

    apply(1, 0, 0, 0);                           // reset with a command on the same edge
    cmd(0, 2); apply(1, 1, 0, 0); apply(1, 0, 1, 1); cmd(3, 1);

    cmd(2, 20);                                  // saturation of 4-bit counters on B
    cmd(1, 20);
    repeat (2) begin cmd(0, 4); cmd(1, 1); end

    for (int burst = 0; burst < 15; burst++) begin
      apply(1, 0, 0, 0);
      for (int i = 0; i < 80; i++) begin
        x = $urandom_range(0, 99);
        if (x < 40)      cmd(0, 1);
        else if (x < 70) cmd(1, 1);
        else if (x < 85) cmd(2, 1);
        else if (x < 97) cmd(3, 1);
        else if (x < 99) apply(0, 1, $urandom_range(0, 1) == 1, 1);
        else             apply(1, $urandom_range(0, 1) == 1, 0, 0);
      end
    end

    @(negedge clock);
    reset = 0; avancar = 0; girar = 0; remover = 0;
    repeat (2) @(negedge clock);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/robo_tracker.md
# robo_tracker

Passive downstream observer of the robot controller's command outputs (`avancar`, `girar`, `remover`), instantiated alongside the controller/environment pair in the top level. It tracks the robot's pose (row, column, heading) on the grid and keeps step/turn/removal counts. It flags illegal command combinations, out-of-grid moves, completed laps (return to the start pose), and, optionally, a stuck robot. It never drives the controller or the environment memory.

## Interface
- `GRID_W`, default 16: grid columns; column range is 0..GRID_W-1.
- `GRID_H`, default 16: grid rows; row range is 0..GRID_H-1. Row 0 is the top row.
- `START_ROW`, default 0: row at reset.
- `START_COL`, default 0: column at reset.
- `START_DIR`, default 2: heading at reset; 0=N, 1=E, 2=S, 3=W.
- `CNT_W`, default 16: width of each counter.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `avancar` in 1: advance one cell in the current heading.
- `girar` in 1: rotate 90° clockwise.
- `remover` in 1: remove the object under the robot.
- `row` out clog2(GRID_H): current row.
- `col` out clog2(GRID_W): current column.
- `dir` out 2: current heading.
- `step_count` out CNT_W: accepted advances.
- `turn_count` out CNT_W: accepted turns.
- `remove_count` out CNT_W: accepted removals.
- `lap_count` out CNT_W: completed laps.
- `lap_done` out 1: one-cycle pulse on each lap completion.
- `illegal_cmd` out 1: sticky; set when more than one command is asserted in the same cycle.
- `out_of_bounds` out 1: sticky; set when an advance would leave the grid.
- `stuck` out 1: sticky; exists only when `TRACKER_STUCK_EN` is defined.

## Operation
- **Sampling.** Commands are sampled on every rising edge; no handshake is used. Command inputs must be one-hot or all zero.
- **Illegal combination.** If two or more commands are high in the same cycle:
  - no pose or counter update occurs;
  - `illegal_cmd` is set.
- **`girar`:**
  - `dir <= dir+1` mod 4 (N→E→S→W→N);
  - `turn_count` increments.
- **`avancar`:**
  - N: row−1. E: col+1. S: row+1. W: col−1.
  - If the target cell is outside 0..GRID_W-1 / 0..GRID_H-1, the pose holds, `out_of_bounds` is set, and `step_count` does not increment.
  - Otherwise the pose moves and `step_count` increments.
- **`remover`:** `remove_count` increments; pose unchanged.
- **Counters.** All counters saturate at 2^CNT_W−1 and never wrap.
- **Lap detection.**
  - An internal `moved` flag sets on the first accepted advance.
  - A lap is complete when an accepted `avancar` or `girar` produces a pose equal to (START_ROW, START_COL, START_DIR) while `moved`=1.
  - On lap completion: `lap_done` pulses, `lap_count` increments, and `moved` clears. The next lap requires another advance.
  - Turning in place at the start cell never produces a lap before the first advance.
- **Sticky flags** clear only on reset.

## Timing
- Reset values:
  - `row`=START_ROW, `col`=START_COL, `dir`=START_DIR;
  - all counters 0;
  - `lap_done`, `illegal_cmd`, `out_of_bounds`, `stuck` = 0;
  - `moved`=0 and the internal girar-run counter = 0.
- **Latency.** A command sampled at edge k is reflected in all outputs immediately after edge k. `lap_done` is high for exactly the cycle following edge k.
- **Back-to-back commands.** Each cycle is independent; commands on consecutive cycles are all applied.
- **Reset mid-operation.** Reset has priority over any command on the same edge. The command is discarded and all state returns to reset values.
- **Out-of-bounds in the same cycle as lap logic.** No lap is detected, because the pose did not change.

## Configuration
- **Macro: `TRACKER_STUCK_EN`.**
- **Defined:**
  - A 3-bit run counter counts consecutive accepted `girar` with no accepted `avancar` in between.
  - An accepted `avancar` or a reset clears the run counter. `remover` and idle cycles do not clear it.
  - When the run counter reaches 4, `stuck` is set (sticky). The robot has rotated a full circle without finding a free cell.
  - `stuck` rises on the edge that accepts the 4th turn.
- **Undefined:** the `stuck` port, the run counter and the associated logic are absent. All other behaviour is identical.

## Test plan
- **Reset and single moves.** Reset with defaults, then `avancar` ×3 → row=3, col=0, dir=2, step_count=3, all flags 0.
- **Square lap.** Defaults with START_DIR=1 at (0,0). Sequence: avancar ×2, girar, avancar ×2, girar, avancar ×2, girar, avancar ×2, girar. Expected:
  - `lap_done` pulses once on the final turn;
  - lap_count=1, step_count=8, turn_count=4.
- **Boundary.** From (0,0) with dir=N, `avancar` → pose unchanged, `out_of_bounds`=1, step_count=0. A following `girar` still works: dir=E.
- **Illegal combination.** `avancar`=`girar`=1 in one cycle → pose and counters unchanged, `illegal_cmd`=1. The flag stays 1 after subsequent legal commands.
- **Stuck detection (`TRACKER_STUCK_EN` defined).**
  - `girar` ×3, `avancar`, `girar` ×3 → `stuck`=0.
  - One more `girar` → `stuck`=1.
  - Also confirm that `remover` between turns does not clear the run counter.
- **Reset mid-operation and saturation.**
  - Assert reset together with `avancar` → all outputs at reset values on the next cycle.
  - Separately, with CNT_W=4, apply `remover` ×20 → remove_count=15.
